// File: rtl/pcs1x_rx_blocklock.sv
// 64b/66b receive block aligner for one PCS1x lane: sync-header hunt, lock, slip.
// Define BLOCKLOCK_ERRCNT_EN to add the saturating bad-header counter.
module pcs1x_rx_blocklock #(
    parameter int LOCK_CNT  = 64,
    parameter int WIN_CNT   = 64,
    parameter int BAD_MAX   = 16,
    parameter int SLIP_WAIT = 2
) (
    input  logic        clkpma_rx,
    input  logic        reset_n_rx,
    input  logic        in_enable,
    input  logic        in_rxdata_en,
    input  logic [65:0] in_rxdata,
    output logic [65:0] out_rxblock,
    output logic        out_rxblock_valid,
    output logic        out_block_lock,
    output logic [6:0]  out_slip_offset,
    input  logic        in_clr_errcnt,
    output logic [15:0] out_bad_hdr_cnt
);
    localparam int SW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WIN_CNT + 1);
    localparam int BW = $clog2(BAD_MAX + 1);
    localparam int AW = $clog2(SLIP_WAIT + 2);

    localparam logic [SW-1:0] SH_LAST   = SW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_CNT);
    localparam logic [BW-1:0] BAD_LIM   = BW'(BAD_MAX);
    localparam logic [AW-1:0] WAIT_LAST = AW'(SLIP_WAIT - 1);
    localparam logic [6:0]    OFF_MAX   = 7'd65;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sh_cnt_q, sh_cnt_d;
    logic [WW-1:0]   win_cnt_q, win_cnt_d, win_inc;
    logic [BW-1:0]   bad_cnt_q, bad_cnt_d, bad_inc;
    logic [AW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [6:0]      offset_q, offset_d;
    logic [65:0]     prev_q, prev_d;
    logic [65:0]     rxblock_q, rxblock_d;
    logic            valid_q, valid_d;

    logic [131:0]    cat;
    logic [65:0]     aligned;
    logic            hdr_ok;
    logic            slip;
    logic            win_end;
    logic            bad_trip;

    // Previous word sits in the low half, so offset 0 selects the older word.
    assign cat      = {in_rxdata, prev_q};
    assign aligned  = 66'(cat >> offset_q);
    assign hdr_ok   = aligned[1] ^ aligned[0];
    assign win_inc  = win_cnt_q + WW'(1);
    assign bad_inc  = bad_cnt_q + BW'(!hdr_ok);
    assign win_end  = (win_inc == WIN_LAST);
    assign bad_trip = (bad_inc == BAD_LIM);

    // State register
    always_ff @(posedge clkpma_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) state_q <= ST_HUNT;
        else             state_q <= state_d;
    end

    // Next state; slip is a one-edge action that lands in WAIT
    always_comb begin
        state_d = state_q;
        slip    = 1'b0;
        if (!in_enable) begin
            state_d = ST_HUNT;
        end else if (in_rxdata_en) begin
            case (state_q)
                ST_HUNT: begin
                    if (!hdr_ok)                  slip    = 1'b1;
                    else if (sh_cnt_q == SH_LAST) state_d = ST_LOCKED;
                end
                ST_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) state_d = ST_HUNT;
                end
                ST_LOCKED: begin
                    if (bad_trip) slip = 1'b1;
                end
                default: state_d = ST_HUNT;
            endcase
            if (slip) state_d = (SLIP_WAIT == 0) ? ST_HUNT : ST_WAIT;
        end
    end

    // Outputs
    always_comb begin
        out_block_lock    = (state_q == ST_LOCKED);
        out_rxblock_valid = valid_q;
        out_rxblock       = rxblock_q;
        out_slip_offset   = offset_q;
    end

    // Counters and offset advance only on accepted blocks
    always_comb begin
        sh_cnt_d   = sh_cnt_q;
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        wait_cnt_d = wait_cnt_q;
        offset_d   = offset_q;
        if (!in_enable) begin
            sh_cnt_d   = '0;
            win_cnt_d  = '0;
            bad_cnt_d  = '0;
            wait_cnt_d = '0;
        end else if (in_rxdata_en) begin
            if (slip) begin
                sh_cnt_d   = '0;
                win_cnt_d  = '0;
                bad_cnt_d  = '0;
                wait_cnt_d = '0;
                offset_d   = (offset_q >= OFF_MAX) ? 7'd0 : offset_q + 7'd1;
            end else begin
                case (state_q)
                    ST_HUNT:
                        sh_cnt_d = (sh_cnt_q == SH_LAST) ? '0 : sh_cnt_q + SW'(1);
                    ST_WAIT:
                        wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? '0 : wait_cnt_q + AW'(1);
                    ST_LOCKED: begin
                        // Last block of a window has already been counted in bad_inc.
                        if (win_end) begin
                            win_cnt_d = '0;
                            bad_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_inc;
                            bad_cnt_d = bad_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        prev_d    = in_rxdata_en ? in_rxdata : prev_q;
        rxblock_d = in_rxdata_en ? aligned : rxblock_q;
        valid_d   = in_rxdata_en & in_enable;
    end

    always_ff @(posedge clkpma_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            sh_cnt_q   <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            offset_q   <= '0;
            prev_q     <= '0;
            rxblock_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            sh_cnt_q   <= sh_cnt_d;
            win_cnt_q  <= win_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            offset_q   <= offset_d;
            prev_q     <= prev_d;
            rxblock_q  <= rxblock_d;
            valid_q    <= valid_d;
        end
    end

`ifdef BLOCKLOCK_ERRCNT_EN
    logic [15:0] errcnt_q, errcnt_d;

    // Clear beats a same-cycle increment; loss of lock leaves the count alone.
    always_comb begin
        errcnt_d = errcnt_q;
        if (in_clr_errcnt)
            errcnt_d = '0;
        else if (in_enable && in_rxdata_en && state_q == ST_LOCKED && !hdr_ok
                 && errcnt_q != 16'hFFFF)
            errcnt_d = errcnt_q + 16'd1;
    end

    always_ff @(posedge clkpma_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) errcnt_q <= '0;
        else             errcnt_q <= errcnt_d;
    end

    assign out_bad_hdr_cnt = errcnt_q;
`else
    logic unused_clr;
    assign unused_clr      = in_clr_errcnt;
    assign out_bad_hdr_cnt = '0;
`endif

endmodule

// File: tb/tb_pcs1x_rx_blocklock.sv
// Randomized bench for pcs1x_rx_blocklock: a bit-level line model feeds the DUT and a
// behavioural hunt/lock model predicts every output each cycle.
module tb_pcs1x_rx_blocklock;
    localparam int LOCK_CNT = 64;
    localparam int WIN_CNT  = 64;
    localparam int BAD_MAX  = 16;
    localparam int SLIP_WT  = 2;
`ifdef BLOCKLOCK_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clkpma_rx = 1'b0;
    logic        reset_n_rx = 1'b0;
    logic        in_enable = 1'b0;
    logic        in_rxdata_en = 1'b0;
    logic [65:0] in_rxdata = '0;
    logic        in_clr_errcnt = 1'b0;
    logic [65:0] out_rxblock;
    logic        out_rxblock_valid;
    logic        out_block_lock;
    logic [6:0]  out_slip_offset;
    logic [15:0] out_bad_hdr_cnt;

    pcs1x_rx_blocklock dut (
        .clkpma_rx        (clkpma_rx),
        .reset_n_rx       (reset_n_rx),
        .in_enable        (in_enable),
        .in_rxdata_en     (in_rxdata_en),
        .in_rxdata        (in_rxdata),
        .out_rxblock      (out_rxblock),
        .out_rxblock_valid(out_rxblock_valid),
        .out_block_lock   (out_block_lock),
        .out_slip_offset  (out_slip_offset),
        .in_clr_errcnt    (in_clr_errcnt),
        .out_bad_hdr_cnt  (out_bad_hdr_cnt)
    );

    always #5 clkpma_rx = ~clkpma_rx;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transmit side: a serial line of 66-bit blocks, optionally pre-shifted
    bit tx_q[$];
    int tx_bad = 0;

    function automatic void tx_start(input int shift);
        tx_q.delete();
        tx_bad = 0;
        for (int i = 0; i < shift; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
    endfunction

    function automatic void tx_push_block();
        logic [1:0]  h;
        logic [63:0] p;
        if (tx_bad > 0) begin
            h = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
            tx_bad--;
        end else begin
            h = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
        end
        p = {$urandom(), $urandom()};
        tx_q.push_back(h[0]);
        tx_q.push_back(h[1]);
        for (int i = 0; i < 64; i++) tx_q.push_back(p[i]);
    endfunction

    function automatic logic [65:0] tx_word();
        logic [65:0] w;
        while (tx_q.size() < 66) tx_push_block();
        for (int i = 0; i < 66; i++) w[i] = tx_q.pop_front();
        return w;
    endfunction

    // Receive model: blocks are read off the line at the current bit offset
    logic [65:0] m_prev, m_out;
    bit          m_valid, m_locked;
    int          m_off, m_good, m_wait, m_win, m_bad, m_err;

    function automatic void model_reset();
        m_prev = '0; m_out = '0; m_valid = 0; m_locked = 0;
        m_off = 0; m_good = 0; m_wait = 0; m_win = 0; m_bad = 0; m_err = 0;
    endfunction

    function automatic logic [65:0] align(input logic [65:0] p, input logic [65:0] c, input int off);
        logic [65:0] a;
        for (int i = 0; i < 66; i++) a[i] = (off + i < 66) ? p[off + i] : c[off + i - 66];
        return a;
    endfunction

    function automatic void do_slip();
        m_off    = (m_off + 1) % 66;
        m_good   = 0; m_win = 0; m_bad = 0;
        m_locked = 0;
        m_wait   = SLIP_WT;
    endfunction

    function automatic void model_edge(input bit enb, input bit en, input logic [65:0] d, input bit clr);
        logic [65:0] a;
        bit ok;
        a = align(m_prev, d, m_off);
        ok = (a[1:0] == 2'b01) || (a[1:0] == 2'b10);
        if (en) begin m_out = a; m_prev = d; end
        m_valid = en && enb;
        if (!enb) begin
            m_locked = 0; m_good = 0; m_wait = 0; m_win = 0; m_bad = 0;
        end else if (en) begin
            if (m_wait > 0) m_wait--;
            else if (!m_locked) begin
                if (!ok) do_slip();
                else begin
                    m_good++;
                    if (m_good == LOCK_CNT) m_locked = 1;
                end
            end else begin
                m_win++;
                if (!ok) begin
                    m_bad++;
                    if (m_err < 65535) m_err++;
                end
                if (m_bad == BAD_MAX) do_slip();
                else if (m_win == WIN_CNT) begin m_win = 0; m_bad = 0; end
            end
        end
        if (clr) m_err = 0;
    endfunction

    task automatic compare_all();
        chk("valid",  66'(out_rxblock_valid), 66'(m_valid));
        chk("lock",   66'(out_block_lock),    66'(m_locked));
        chk("offset", 66'(out_slip_offset),   66'(m_off));
        chk("errcnt", 66'(out_bad_hdr_cnt),   ERR_EN ? 66'(m_err) : 66'(0));
        if (m_valid) chk("block", out_rxblock, m_out);
    endtask

    task automatic step(input bit en, input bit enb, input bit clr);
        logic [65:0] d;
        d = en ? tx_word() : 66'({$urandom(), $urandom(), $urandom()});
        in_rxdata = d; in_rxdata_en = en; in_enable = enb; in_clr_errcnt = clr;
        @(posedge clkpma_rx);
        model_edge(enb, en, d, clr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clkpma_rx);
        reset_n_rx = 1'b0;
        in_enable = 1'b0; in_rxdata_en = 1'b0; in_clr_errcnt = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clkpma_rx);
        reset_n_rx = 1'b1;
    endtask

    task automatic run_to_lock(input int budget);
        int n = 0;
        while (!m_locked && n < budget) begin step(1, 1, 0); n++; end
        chk("lock_reached", 66'(out_block_lock), 66'(1));
    endtask

    task automatic sync_window();
        int n = 0;
        do begin step(1, 1, 0); n++; end while (m_win != 0 && n < WIN_CNT + 8);
    endtask

    task automatic run_to_drop(input int budget);
        int n = 0;
        while (m_locked && n < budget) begin step(1, 1, 0); n++; end
        chk("lock_dropped", 66'(out_block_lock), 66'(0));
    endtask

    initial begin
        bit lost;
        // 1: clean stream at offset 0; one primer word fills the history register
        do_reset();
        tx_start(0);
        step(1, 0, 0);
        for (int i = 0; i < LOCK_CNT - 1; i++) step(1, 1, 0);
        chk("t1_lock63", 66'(out_block_lock), 66'(0));
        step(1, 1, 0);
        chk("t1_lock64", 66'(out_block_lock), 66'(1));
        chk("t1_off", 66'(out_slip_offset), 66'(0));

        // 2: stream shifted by 37 bits
        do_reset();
        tx_start(37);
        step(1, 0, 0);
        run_to_lock(3000);
        chk("t2_off", 66'(out_slip_offset), 66'(37));
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0);
            chk("t2_hdr", 66'(out_rxblock[1] ^ out_rxblock[0]), 66'(1));
        end

        // 3: 15 bad headers in a window hold lock, 16 drop it
        sync_window();
        tx_bad = BAD_MAX - 1;
        for (int i = 0; i < 60; i++) step(1, 1, 0);
        chk("t3_hold15", 66'(out_block_lock), 66'(1));
        sync_window();
        tx_bad = BAD_MAX;
        run_to_drop(40);
        chk("t3_off_inc", 66'(out_slip_offset), 66'(38));
        for (int i = 0; i < 6; i++) step(1, 1, 0);

        // 4: lock at 65, loss wraps the offset to 0
        do_reset();
        tx_start(65);
        step(1, 0, 0);
        run_to_lock(3000);
        chk("t4_off65", 66'(out_slip_offset), 66'(65));
        sync_window();
        tx_bad = BAD_MAX;
        run_to_drop(40);
        chk("t4_wrap", 66'(out_slip_offset), 66'(0));
        for (int i = 0; i < 8; i++) step(1, 1, 0);

        // 5: gappy input while locked, then an enable drop and relock
        do_reset();
        tx_start(0);
        step(1, 0, 0);
        run_to_lock(200);
        lost = 0;
        for (int i = 0; i < 200; i++) begin
            step(bit'($urandom_range(0, 1)), 1, 0);
            if (!out_block_lock) lost = 1;
        end
        chk("t5_no_loss", 66'(lost), 66'(0));
        step(1, 0, 0);
        chk("t5_en_lock", 66'(out_block_lock), 66'(0));
        chk("t5_en_vld", 66'(out_rxblock_valid), 66'(0));
        chk("t5_en_off", 66'(out_slip_offset), 66'(0));
        for (int i = 0; i < LOCK_CNT - 1; i++) step(1, 1, 0);
        chk("t5_relock63", 66'(out_block_lock), 66'(0));
        step(1, 1, 0);
        chk("t5_relock64", 66'(out_block_lock), 66'(1));

        // 6: error counter, then asynchronous reset while locked
        sync_window();
        tx_bad = 3;
        for (int i = 0; i < 10; i++) step(1, 1, 0);
        chk("t6_err3", 66'(out_bad_hdr_cnt), ERR_EN ? 66'(3) : 66'(0));
        step(1, 1, 1);
        chk("t6_clr", 66'(out_bad_hdr_cnt), 66'(0));
        chk("t6_prelock", 66'(out_block_lock), 66'(1));
        reset_n_rx = 1'b0;
        model_reset();
        #2;
        chk("t6_rst_lock", 66'(out_block_lock), 66'(0));
        chk("t6_rst_vld", 66'(out_rxblock_valid), 66'(0));
        chk("t6_rst_off", 66'(out_slip_offset), 66'(0));
        compare_all();
        @(negedge clkpma_rx);
        reset_n_rx = 1'b1;
        step(1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
